// File: rtl/bus_arbiter.sv
// Three-master arbiter for one shared slave port: core (m0), jtag (m1) and uart debug (m2).
// One access in flight at a time; debug masters win by priority, with a starvation guard for the core.
module bus_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int STARVE  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  input  logic        m2_req_i,
  input  logic        m2_we_i,
  input  logic [31:0] m2_addr_i,
  input  logic [31:0] m2_data_i,
  output logic [31:0] m2_data_o,
  output logic        m2_ack_o,
  output logic        m2_err_o,
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i,
  output logic        hold_o
);

  localparam int WAIT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int STARVE_W = (STARVE > 0) ? $clog2(STARVE + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [1:0]          owner_reg, owner_next;
  logic                we_reg, we_next;
  logic [31:0]         addr_reg, addr_next;
  logic [31:0]         wdata_reg, wdata_next;
  logic [31:0]         rdata_reg, rdata_next;
  logic                err_reg, err_next;
  logic [STARVE_W-1:0] starve_reg, starve_next;
  logic [WAIT_W-1:0]   wait_reg, wait_next;

  logic [2:0]  req_vec;
  logic        we_vec    [3];
  logic [31:0] addr_vec  [3];
  logic [31:0] wdata_vec [3];

  assign req_vec      = {m2_req_i, m1_req_i, m0_req_i};
  assign we_vec[0]    = m0_we_i;
  assign we_vec[1]    = m1_we_i;
  assign we_vec[2]    = m2_we_i;
  assign addr_vec[0]  = m0_addr_i;
  assign addr_vec[1]  = m1_addr_i;
  assign addr_vec[2]  = m2_addr_i;
  assign wdata_vec[0] = m0_data_i;
  assign wdata_vec[1] = m1_data_i;
  assign wdata_vec[2] = m2_data_i;

  logic       grant_valid;
  logic [1:0] grant_idx;

  // The core jumps the queue only once the debug masters have starved it STARVE times.
  always_comb begin
    grant_valid = |req_vec;
    grant_idx   = 2'd0;
    if (req_vec[0] && (starve_reg == STARVE_W'(STARVE))) begin
      grant_idx = 2'd0;
    end else if (req_vec[1]) begin
      grant_idx = 2'd1;
    end else if (req_vec[2]) begin
      grant_idx = 2'd2;
    end else begin
      grant_idx = 2'd0;
    end
  end

  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    we_next     = we_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    rdata_next  = rdata_reg;
    err_next    = err_reg;
    starve_next = starve_reg;
    wait_next   = wait_reg;
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          state_next = BUSY;
          owner_next = grant_idx;
          we_next    = we_vec[grant_idx];
          addr_next  = addr_vec[grant_idx];
          wdata_next = wdata_vec[grant_idx];
          wait_next  = '0;
          if (grant_idx == 2'd0) begin
            starve_next = '0;
          end else if (req_vec[0] && (starve_reg < STARVE_W'(STARVE))) begin
            starve_next = starve_reg + STARVE_W'(1);
          end
        end
      end
      BUSY: begin
        // A slave ack in the final wait cycle still beats the timeout.
        if (s_ack_i) begin
          state_next = DONE;
          rdata_next = we_reg ? 32'd0 : s_data_i;
          err_next   = 1'b0;
        end else if (wait_reg == WAIT_W'(TIMEOUT - 1)) begin
          state_next = DONE;
          rdata_next = 32'd0;
          err_next   = 1'b1;
        end else begin
          wait_next = wait_reg + WAIT_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      owner_reg  <= 2'd0;
      we_reg     <= 1'b0;
      addr_reg   <= 32'd0;
      wdata_reg  <= 32'd0;
      rdata_reg  <= 32'd0;
      err_reg    <= 1'b0;
      starve_reg <= '0;
      wait_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      we_reg     <= we_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      rdata_reg  <= rdata_next;
      err_reg    <= err_next;
      starve_reg <= starve_next;
      wait_reg   <= wait_next;
    end
  end

  // Outputs are masked by rst so nothing leaks while reset is held mid-access.
  logic busy_live, done_live;
  assign busy_live = !rst && (state_reg == BUSY);
  assign done_live = !rst && (state_reg == DONE);

  assign s_req_o  = busy_live;
  assign s_we_o   = busy_live & we_reg;
  assign s_addr_o = busy_live ? addr_reg : 32'd0;
  assign s_data_o = busy_live ? wdata_reg : 32'd0;
  assign hold_o   = !rst && (state_reg != IDLE) && (owner_reg != 2'd0);

  logic [2:0]  ack_vec, err_vec;
  logic [31:0] rdata_vec [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_master
      assign ack_vec[gi]   = done_live && (owner_reg == 2'(gi));
      assign err_vec[gi]   = ack_vec[gi] & err_reg;
      assign rdata_vec[gi] = ack_vec[gi] ? rdata_reg : 32'd0;
    end
  endgenerate

  assign m0_ack_o  = ack_vec[0];
  assign m1_ack_o  = ack_vec[1];
  assign m2_ack_o  = ack_vec[2];
  assign m0_err_o  = err_vec[0];
  assign m1_err_o  = err_vec[1];
  assign m2_err_o  = err_vec[2];
  assign m0_data_o = rdata_vec[0];
  assign m1_data_o = rdata_vec[1];
  assign m2_data_o = rdata_vec[2];

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model of the arbiter.
module tb_bus_arbiter;

  localparam int TIMEOUT = 255;
  localparam int STARVE  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] dout  [3];
  logic        m0_ack_o, m1_ack_o, m2_ack_o;
  logic        m0_err_o, m1_err_o, m2_err_o;
  logic        s_req_o, s_we_o, s_ack_i, hold_o;
  logic [31:0] s_addr_o, s_data_o, s_data_i;
  logic [2:0]  ackv, errv;

  assign ackv = {m2_ack_o, m1_ack_o, m0_ack_o};
  assign errv = {m2_err_o, m1_err_o, m0_err_o};

  bus_arbiter #(.TIMEOUT(TIMEOUT), .STARVE(STARVE)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(req[0]), .m0_we_i(we[0]), .m0_addr_i(addr[0]), .m0_data_i(wdata[0]),
    .m0_data_o(dout[0]), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_req_i(req[1]), .m1_we_i(we[1]), .m1_addr_i(addr[1]), .m1_data_i(wdata[1]),
    .m1_data_o(dout[1]), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .m2_req_i(req[2]), .m2_we_i(we[2]), .m2_addr_i(addr[2]), .m2_data_i(wdata[2]),
    .m2_data_o(dout[2]), .m2_ack_o(m2_ack_o), .m2_err_o(m2_err_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_data_o(s_data_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i), .hold_o(hold_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Slave configuration, written only by the main process.
  int          sl_lat   = 0;
  bit          sl_never = 1'b0;
  bit          sl_rand  = 1'b0;
  logic [31:0] sl_data  = 32'd0;

  // Slave: acks after a chosen number of BUSY cycles (0 = same cycle as s_req_o), or never.
  initial begin
    int cnt, cur_lat;
    bit cur_never;
    s_ack_i = 1'b0; s_data_i = 32'd0; cnt = 0; cur_lat = 0; cur_never = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (s_req_o) begin
        if (cnt == 0) begin
          if (sl_rand) begin
            cur_lat   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 20)) : int'($urandom_range(0, 3));
            cur_never = ($urandom_range(0, 63) == 0);
          end else begin
            cur_lat   = sl_lat;
            cur_never = sl_never;
          end
        end
        if (!cur_never && cnt == cur_lat) begin
          s_ack_i  = 1'b1;
          s_data_i = sl_rand ? $urandom : sl_data;
        end else begin
          s_ack_i  = 1'b0;
          s_data_i = $urandom;
        end
        cnt++;
      end else begin
        s_ack_i  = 1'b0;
        s_data_i = $urandom;
        cnt      = 0;
      end
    end
  end

  // Behavioural model: phase 0 idle, 1 access on the bus, 2 completion being reported.
  int          ph = 0, own = 0, starve = 0, waits = 0;
  bit          mwe = 1'b0, merr = 1'b0;
  logic [31:0] maddr = 32'd0, mwd = 32'd0, mrd = 32'd0;

  initial begin
    int g;
    forever begin
      @(posedge clk);
      if (rst) begin
        ph = 0; own = 0; starve = 0; waits = 0; mrd = 32'd0; merr = 1'b0;
      end else if (ph == 0) begin
        g = -1;
        if (req[0] && starve == STARVE) g = 0;
        else if (req[1]) g = 1;
        else if (req[2]) g = 2;
        else if (req[0]) g = 0;
        if (g >= 0) begin
          if (g == 0) starve = 0;
          else if (req[0]) starve = (starve < STARVE) ? starve + 1 : STARVE;
          own = g; mwe = we[g]; maddr = addr[g]; mwd = wdata[g];
          waits = 0; ph = 1;
        end
      end else if (ph == 1) begin
        waits++;
        if (s_ack_i) begin
          mrd = mwe ? 32'd0 : s_data_i; merr = 1'b0; ph = 2;
        end else if (waits == TIMEOUT) begin
          mrd = 32'd0; merr = 1'b1; ph = 2;
        end
      end else begin
        ph = 0;
      end
    end
  end

  // Compare every cycle on the falling edge.
  initial begin
    bit e_sreq, e_ack;
    forever begin
      @(negedge clk);
      e_sreq = !rst && ph == 1;
      chk("s_req", s_req_o, e_sreq);
      chk("s_we", s_we_o, e_sreq && mwe);
      chk("s_addr", s_addr_o, e_sreq ? maddr : 32'd0);
      chk("s_data", s_data_o, e_sreq ? mwd : 32'd0);
      chk("hold", hold_o, !rst && ph != 0 && own != 0);
      for (int n = 0; n < 3; n++) begin
        e_ack = !rst && ph == 2 && own == n;
        chk($sformatf("m%0d_ack", n), ackv[n], e_ack);
        chk($sformatf("m%0d_err", n), errv[n], e_ack && merr);
        chk($sformatf("m%0d_data", n), dout[n], e_ack ? mrd : 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  int ack_q[$], hold_q[$], err_q[$], gap_q[$];
  logic [31:0] data_q[$];
  int rises, busy_cycles;

  // Run until `want` acks arrive; masters not in `keep` drop their request on ack.
  task automatic collect(input int want, input int budget, input logic [2:0] keep);
    int cyc, zr;
    bit prev;
    ack_q.delete(); hold_q.delete(); err_q.delete(); data_q.delete(); gap_q.delete();
    rises = 0; busy_cycles = 0; prev = s_req_o; zr = 0; cyc = 0;
    while (ack_q.size() < want && cyc < budget) begin
      tick(); cyc++;
      if (s_req_o) begin
        busy_cycles++;
        if (!prev) begin
          rises++;
          if (rises > 1) gap_q.push_back(zr);
        end
        zr = 0;
      end else begin
        zr++;
      end
      prev = s_req_o;
      for (int n = 0; n < 3; n++) begin
        if (ackv[n]) begin
          ack_q.push_back(n); hold_q.push_back(int'(hold_o));
          err_q.push_back(int'(errv[n])); data_q.push_back(dout[n]);
          if (!keep[n]) req[n] = 1'b0;
        end
      end
    end
    chk("collect_count", ack_q.size(), want);
  endtask

  initial begin
    int acks_seen;
    rst = 1'b1; req = 3'b000; we = 3'b000;
    for (int n = 0; n < 3; n++) begin addr[n] = 32'd0; wdata[n] = 32'd0; end

    repeat (3) tick();
    chk("reset_sreq", s_req_o, 0);
    chk("reset_ack", ackv, 0);
    chk("reset_hold", hold_o, 0);
    rst = 1'b0;
    tick();
    chk("idle_sreq", s_req_o, 0);

    // Basic m0 read, slave acks in its first BUSY cycle.
    sl_lat = 0; sl_never = 1'b0; sl_data = 32'hDEADBEEF;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0000_1000;
    tick();
    chk("t1_busy_sreq", s_req_o, 1);
    chk("t1_busy_addr", s_addr_o, 32'h0000_1000);
    chk("t1_busy_hold", hold_o, 0);
    tick();
    chk("t1_ack", m0_ack_o, 1);
    chk("t1_data", dout[0], 32'hDEADBEEF);
    chk("t1_err", m0_err_o, 0);
    chk("t1_hold", hold_o, 0);
    req[0] = 1'b0;
    tick();
    chk("t1_ack_once", m0_ack_o, 0);

    // All three request together: m1, m2, then m0.
    sl_lat = 1; sl_data = 32'h1234_5678;
    for (int n = 0; n < 3; n++) begin addr[n] = 32'h100 * (n + 1); we[n] = 1'b0; end
    req = 3'b111;
    collect(3, 40, 3'b000);
    chk("t2_order0", ack_q[0], 1);
    chk("t2_order1", ack_q[1], 2);
    chk("t2_order2", ack_q[2], 0);
    chk("t2_hold_m1", hold_q[0], 1);
    chk("t2_hold_m2", hold_q[1], 1);
    chk("t2_hold_m0", hold_q[2], 0);
    chk("t2_data_m1", data_q[0], 32'h1234_5678);

    // m1 hammers the bus while m0 waits; the 5th grant goes to m0, twice in a row.
    sl_lat = 0;
    for (int round = 0; round < 2; round++) begin
      req[1] = 1'b1; req[0] = 1'b1;
      collect(5, 60, 3'b010);
      for (int k = 0; k < 4; k++) chk($sformatf("t3_r%0d_m1_grant%0d", round, k), ack_q[k], 1);
      chk($sformatf("t3_r%0d_m0_grant", round), ack_q[4], 0);
      chk($sformatf("t3_r%0d_txn_per_ack", round), rises, 5);
      foreach (gap_q[k]) chk($sformatf("t3_r%0d_gap%0d", round, k), gap_q[k], 2);
    end
    req[1] = 1'b0;

    // Slave never answers: timeout after exactly TIMEOUT busy cycles.
    sl_never = 1'b1;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0000_2000;
    collect(1, 300, 3'b000);
    chk("t4_busy_cycles", busy_cycles, 255);
    chk("t4_owner", ack_q[0], 0);
    chk("t4_err", err_q[0], 1);
    chk("t4_data", data_q[0], 32'd0);
    sl_never = 1'b0; sl_lat = 2; sl_data = 32'h5555_AAAA;
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h0000_3000; wdata[2] = 32'hA5A5_0001;
    collect(1, 20, 3'b000);
    chk("t4_next_owner", ack_q[0], 2);
    chk("t4_next_err", err_q[0], 0);
    chk("t4_next_wdata0", data_q[0], 32'd0);

    // Reset in the middle of an m2 write.
    sl_never = 1'b1;
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h0000_4000; wdata[2] = 32'h0BAD_F00D;
    tick(); tick();
    chk("t5_busy", s_req_o, 1);
    rst = 1'b1; req[2] = 1'b0; sl_never = 1'b0; sl_lat = 0; sl_data = 32'hCAFE_F00D;
    #1;
    chk("t5_rst_sreq", s_req_o, 0);
    chk("t5_rst_hold", hold_o, 0);
    chk("t5_rst_ack", ackv, 0);
    tick();
    rst = 1'b0;
    chk("t5_post_sreq", s_req_o, 0);
    chk("t5_post_ack", ackv, 0);
    chk("t5_post_addr", s_addr_o, 0);
    repeat (3) begin tick(); chk("t5_no_m2_ack", m2_ack_o, 0); end
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0000_5000;
    tick();
    chk("t5_m0_busy", s_req_o, 1);
    tick();
    chk("t5_m0_ack", m0_ack_o, 1);
    chk("t5_m0_data", dout[0], 32'hCAFE_F00D);
    req[0] = 1'b0;
    tick();

    // Randomized traffic; the compare process checks every cycle.
    sl_rand = 1'b1;
    acks_seen = 0;
    for (int i = 0; i < 4000; i++) begin
      tick();
      rst = ($urandom_range(0, 499) == 0);
      for (int n = 0; n < 3; n++) begin
        if (ackv[n]) begin
          acks_seen++;
          if ($urandom_range(0, 3) != 0) req[n] = 1'b0;
        end else if (!req[n]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[n] = 1'b1; we[n] = 1'($urandom_range(0, 1));
            addr[n] = $urandom; wdata[n] = $urandom;
          end
        end else if ($urandom_range(0, 31) == 0) begin
          req[n] = 1'b0;
        end
      end
    end
    rst = 1'b0; req = 3'b000;
    chk("rand_activity", acks_seen > 100, 1);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
